// File: rtl/tree_node_mem_pkg.sv
// Shared constants for the decision-tree node store and the control stage that consumes it.
// Node word layout, MSB first: child flags, one-position mask, coefficients, bias, spare bit.
package tree_node_mem_pkg;

   localparam int unsigned Features    = 3;
   localparam int unsigned CoeffWidth  = 4;
   localparam int unsigned BiasWidth   = 10;
   localparam int unsigned MaxClusters = 5;

   function automatic int unsigned calc_node_size(input int unsigned features,
                                                  input int unsigned coeff_width,
                                                  input int unsigned bias_width);
      return 2 + features + (features - 1) * coeff_width + bias_width + 1;
   endfunction

   function automatic int unsigned calc_words(input int unsigned channels,
                                              input int unsigned nodes);
      return channels * nodes;
   endfunction

   // Address width that never collapses to zero bits.
   function automatic int unsigned max1_clog2(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int unsigned NodeSize      = calc_node_size(Features, CoeffWidth, BiasWidth);
   localparam int unsigned ChildFlagsLsb = NodeSize - 2;
   localparam int unsigned MaskLsb       = ChildFlagsLsb - Features;
   localparam int unsigned BiasLsb       = 1;

   function automatic int unsigned coeff_lsb(input int unsigned idx);
      return MaskLsb - (idx + 1) * CoeffWidth;
   endfunction

   typedef logic [NodeSize-1:0] node_word_t;

   typedef enum logic [1:0] {
      StIdle,
      StLoading,
      StReady
   } load_state_e;

endpackage

// File: rtl/tree_node_mem_cfg_shift_rx.sv
// Serial-to-parallel receiver for node words: MSB-first shift register plus bit counter,
// pulsing word_valid_o in the cycle the final bit of a word arrives.
module tree_node_mem_cfg_shift_rx #(
   parameter int unsigned Width = 24
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clear_i,
   input  logic             shift_i,
   input  logic             bit_i,
   output logic             word_valid_o,
   output logic [Width-1:0] word_o
);

   localparam int unsigned CntW = $clog2(Width);

   logic [Width-2:0] sr_q, sr_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             last_bit;

   assign last_bit = (cnt_q == CntW'(Width - 1));

   always_comb begin
      sr_d  = sr_q;
      cnt_d = cnt_q;
      if (clear_i) begin
         sr_d  = '0;
         cnt_d = '0;
      end else if (shift_i) begin
         sr_d  = {sr_q[Width-3:0], bit_i};
         cnt_d = last_bit ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sr_q  <= '0;
         cnt_q <= '0;
      end else begin
         sr_q  <= sr_d;
         cnt_q <= cnt_d;
      end
   end

   assign word_valid_o = shift_i && !clear_i && last_bit;
   assign word_o       = {sr_q, bit_i};

endmodule

// File: rtl/tree_node_mem.sv
// Per-channel decision-tree node store: loaded serially once, then read combinationally
// by channel and node index once the whole image has arrived.
module tree_node_mem
   import tree_node_mem_pkg::*;
#(
   parameter int unsigned FEATURES      = 3,
   parameter int unsigned COEFF_WIDTH   = 4,
   parameter int unsigned BIAS_WIDTH    = 10,
   parameter int unsigned MAX_CLUSTERS  = 5,
   parameter int unsigned CHANNEL_COUNT = 1,
   localparam int unsigned NODES     = MAX_CLUSTERS,
   localparam int unsigned NODE_SIZE = calc_node_size(FEATURES, COEFF_WIDTH, BIAS_WIDTH),
   localparam int unsigned WORDS     = calc_words(CHANNEL_COUNT, NODES),
   localparam int unsigned CH_AW     = max1_clog2(CHANNEL_COUNT),
   localparam int unsigned NODE_AW   = max1_clog2(NODES)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 cfg_start,
   input  logic                 cfg_en,
   input  logic                 cfg_bit,
   output logic                 cfg_done,
   output logic                 cfg_err,
   input  logic [CH_AW-1:0]     ch_index,
   input  logic [NODE_AW-1:0]   node_index,
   input  logic                 read_mem,
   output logic [NODE_SIZE-1:0] node_data,
   output logic                 mem_ready
);

   localparam int unsigned PtrW  = max1_clog2(WORDS);
   localparam int unsigned AddrW = $clog2(WORDS) + 1;

   load_state_e          state_q, state_d;
   logic [PtrW-1:0]      ptr_q, ptr_d;
   logic                 err_q, err_d;
   logic                 done_q, done_d;
   logic                 mem_we;
   logic                 shift_en;
   logic                 word_valid;
   logic [NODE_SIZE-1:0] rx_word;
   logic [NODE_SIZE-1:0] mem_q [WORDS];
   logic [AddrW-1:0]     rd_addr;
   logic                 rd_hit;

   // A start pulse always wins over a bit arriving in the same cycle.
   assign shift_en = cfg_en && !cfg_start && (state_q == StLoading);

   tree_node_mem_cfg_shift_rx #(
      .Width(NODE_SIZE)
   ) u_shift_rx (
      .clk_i       (clk),
      .rst_i       (reset),
      .clear_i     (cfg_start),
      .shift_i     (shift_en),
      .bit_i       (cfg_bit),
      .word_valid_o(word_valid),
      .word_o      (rx_word)
   );

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      err_d   = err_q;
      done_d  = 1'b0;
      mem_we  = 1'b0;
      if (cfg_start) begin
         state_d = StLoading;
         ptr_d   = '0;
         err_d   = 1'b0;
      end else begin
         case (state_q)
            StLoading: begin
               if (word_valid) begin
                  mem_we = 1'b1;
                  if (ptr_q == PtrW'(WORDS - 1)) begin
                     state_d = StReady;
                     done_d  = 1'b1;
                  end else begin
                     ptr_d = ptr_q + 1'b1;
                  end
               end
            end
            default: begin
               if (cfg_en) err_d = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         ptr_q   <= '0;
         err_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         err_q   <= err_d;
         done_q  <= done_d;
      end
   end

   // Storage is deliberately left out of reset; mem_ready gates every read.
   always_ff @(posedge clk) begin
      if (mem_we) mem_q[ptr_q] <= rx_word;
   end

   always_comb begin
      rd_addr = AddrW'(ch_index) * AddrW'(NODES) + AddrW'(node_index);
      rd_hit  = read_mem && (state_q == StReady) &&
                (32'(node_index) < NODES) && (32'(ch_index) < CHANNEL_COUNT);
      node_data = rd_hit ? mem_q[rd_addr[PtrW-1:0]] : '0;
   end

   assign mem_ready = (state_q == StReady);
   assign cfg_done  = done_q;
   assign cfg_err   = err_q;

endmodule

// File: tb/tb_tree_node_mem.sv
// Directed bench for tree_node_mem: a single-channel instance and a two-channel instance
// share clock and reset; each scenario task checks its own expectations inline.
module tb_tree_node_mem;

   localparam logic [23:0] P1 = 24'h800000;
   localparam logic [23:0] P2 = 24'h5A3C00;
   localparam logic [23:0] P3 = 24'h9D2710;

   logic        clk = 1'b0;
   logic        reset;
   logic        cfg_start, cfg_en, cfg_bit, read_mem;
   logic        cfg_done, cfg_err, mem_ready;
   logic [0:0]  ch_index;
   logic [2:0]  node_index;
   logic [23:0] node_data;

   logic        b_cfg_start, b_cfg_en, b_cfg_bit, b_read_mem;
   logic        b_cfg_done, b_cfg_err, b_mem_ready;
   logic [0:0]  b_ch_index;
   logic [2:0]  b_node_index;
   logic [23:0] b_node_data;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   tree_node_mem dut (
      .clk       (clk),
      .reset     (reset),
      .cfg_start (cfg_start),
      .cfg_en    (cfg_en),
      .cfg_bit   (cfg_bit),
      .cfg_done  (cfg_done),
      .cfg_err   (cfg_err),
      .ch_index  (ch_index),
      .node_index(node_index),
      .read_mem  (read_mem),
      .node_data (node_data),
      .mem_ready (mem_ready)
   );

   tree_node_mem #(
      .CHANNEL_COUNT(2)
   ) dut2 (
      .clk       (clk),
      .reset     (reset),
      .cfg_start (b_cfg_start),
      .cfg_en    (b_cfg_en),
      .cfg_bit   (b_cfg_bit),
      .cfg_done  (b_cfg_done),
      .cfg_err   (b_cfg_err),
      .ch_index  (b_ch_index),
      .node_index(b_node_index),
      .read_mem  (b_read_mem),
      .node_data (b_node_data),
      .mem_ready (b_mem_ready)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit sel, input logic st, input logic en, input logic b);
      if (sel) begin
         b_cfg_start = st; b_cfg_en = en; b_cfg_bit = b;
      end else begin
         cfg_start = st; cfg_en = en; cfg_bit = b;
      end
   endtask

   function automatic logic done_now(input bit sel);
      return sel ? b_cfg_done : cfg_done;
   endfunction

   // Word n of an image is base | n, shifted MSB first; gap inserts an idle cycle between bits.
   task automatic load(input bit sel, input logic [23:0] base, input int nwords, input bit gap,
                       input bit do_start, output bit early_done);
      logic [23:0] w;
      early_done = 1'b0;
      if (do_start) begin
         drive(sel, 1'b1, 1'b0, 1'b0);
         step();
      end
      for (int i = 0; i < nwords; i++) begin
         w = base | 24'(i);
         for (int b = 23; b >= 0; b--) begin
            if (gap && !(i == 0 && b == 23)) begin
               drive(sel, 1'b0, 1'b0, 1'b0);
               step();
               if (done_now(sel)) early_done = 1'b1;
            end
            drive(sel, 1'b0, 1'b1, w[b]);
            step();
            if (!(i == nwords - 1 && b == 0) && done_now(sel)) early_done = 1'b1;
         end
      end
      drive(sel, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      read_mem = 1'b1; node_index = 3'd0; ch_index = 1'b0;
      #1;
      total++;
      if ({mem_ready, cfg_done, cfg_err} !== 3'b000) begin
         bad++; $display("FAIL reset_flags: got %b want 000", {mem_ready, cfg_done, cfg_err});
      end
      total++;
      if (node_data !== 24'h0) begin
         bad++; $display("FAIL reset_read: got %h want 000000", node_data);
      end
   endtask

   task automatic test_load_continuous();
      bit early;
      load(1'b0, P1, 5, 1'b0, 1'b1, early);
      total++;
      if (early || cfg_done !== 1'b1 || mem_ready !== 1'b1) begin
         bad++; $display("FAIL cont_done: early=%0b done=%b ready=%b want 0 1 1",
                         early, cfg_done, mem_ready);
      end
      step();
      total++;
      if (cfg_done !== 1'b0 || mem_ready !== 1'b1) begin
         bad++; $display("FAIL cont_done_pulse: done=%b ready=%b want 0 1", cfg_done, mem_ready);
      end
      for (int n = 0; n < 5; n++) begin
         node_index = 3'(n); read_mem = 1'b1;
         #1;
         total++;
         if (node_data !== (P1 | 24'(n))) begin
            bad++; $display("FAIL cont_read%0d: got %h want %h", n, node_data, P1 | 24'(n));
         end
      end
      node_index = 3'd5;
      #1;
      total++;
      if (node_data !== 24'h0) begin
         bad++; $display("FAIL cont_read_oob: got %h want 000000", node_data);
      end
   endtask

   task automatic test_load_gapped();
      bit early;
      load(1'b0, P2, 5, 1'b1, 1'b1, early);
      total++;
      if (early || cfg_done !== 1'b1 || mem_ready !== 1'b1) begin
         bad++; $display("FAIL gap_done: early=%0b done=%b ready=%b want 0 1 1",
                         early, cfg_done, mem_ready);
      end
      for (int n = 0; n < 5; n++) begin
         node_index = 3'(n); read_mem = 1'b1;
         #1;
         total++;
         if (node_data !== (P2 | 24'(n))) begin
            bad++; $display("FAIL gap_read%0d: got %h want %h", n, node_data, P2 | 24'(n));
         end
      end
   endtask

   task automatic test_restart_midload();
      bit early;
      logic [23:0] w;
      drive(1'b0, 1'b1, 1'b0, 1'b0);
      step();
      for (int k = 0; k < 58; k++) begin
         w = P3 | 24'(k / 24);
         drive(1'b0, 1'b0, 1'b1, w[23 - (k % 24)]);
         step();
      end
      drive(1'b0, 1'b1, 1'b1, 1'b1);
      step();
      total++;
      if (mem_ready !== 1'b0) begin
         bad++; $display("FAIL restart_ready: got %b want 0", mem_ready);
      end
      load(1'b0, P1, 5, 1'b0, 1'b0, early);
      total++;
      if (early || cfg_done !== 1'b1 || mem_ready !== 1'b1) begin
         bad++; $display("FAIL restart_done: early=%0b done=%b ready=%b want 0 1 1",
                         early, cfg_done, mem_ready);
      end
      for (int n = 0; n < 5; n++) begin
         node_index = 3'(n); read_mem = 1'b1;
         #1;
         total++;
         if (node_data !== (P1 | 24'(n))) begin
            bad++; $display("FAIL restart_read%0d: got %h want %h", n, node_data, P1 | 24'(n));
         end
      end
   endtask

   task automatic test_cfg_err();
      node_index = 3'd3; read_mem = 1'b1;
      for (int k = 0; k < 3; k++) begin
         drive(1'b0, 1'b0, 1'b1, 1'b1);
         step();
      end
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      total++;
      if (cfg_err !== 1'b1 || mem_ready !== 1'b1 || cfg_done !== 1'b0) begin
         bad++; $display("FAIL err_set: err=%b ready=%b done=%b want 1 1 0",
                         cfg_err, mem_ready, cfg_done);
      end
      total++;
      if (node_data !== (P1 | 24'd3)) begin
         bad++; $display("FAIL err_data: got %h want %h", node_data, P1 | 24'd3);
      end
      step();
      total++;
      if (cfg_err !== 1'b1) begin
         bad++; $display("FAIL err_sticky: got %b want 1", cfg_err);
      end
      drive(1'b0, 1'b1, 1'b0, 1'b0);
      step();
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      total++;
      if (cfg_err !== 1'b0 || mem_ready !== 1'b0 || node_data !== 24'h0) begin
         bad++; $display("FAIL err_clear: err=%b ready=%b data=%h want 0 0 000000",
                         cfg_err, mem_ready, node_data);
      end
   endtask

   task automatic test_two_channel();
      bit early;
      logic [4:0]  idx [6] = '{5'h0C, 5'h02, 5'h08, 5'h0D, 5'h0F, 5'h10};
      logic [23:0] exp [6] = '{P1 | 24'd9, P1 | 24'd2, P1 | 24'd5, 24'h0, 24'h0, 24'h0};
      load(1'b1, P1, 10, 1'b0, 1'b1, early);
      total++;
      if (early || b_cfg_done !== 1'b1 || b_mem_ready !== 1'b1) begin
         bad++; $display("FAIL ch2_done: early=%0b done=%b ready=%b want 0 1 1",
                         early, b_cfg_done, b_mem_ready);
      end
      // idx = {read_disable, ch, node[2:0]}
      for (int t = 0; t < 6; t++) begin
         b_read_mem   = ~idx[t][4];
         b_ch_index   = idx[t][3];
         b_node_index = idx[t][2:0];
         #1;
         total++;
         if (b_node_data !== exp[t]) begin
            bad++; $display("FAIL ch2_read%0d: got %h want %h", t, b_node_data, exp[t]);
         end
      end
   endtask

   task automatic test_reset_midload();
      bit early;
      logic [23:0] w;
      drive(1'b0, 1'b1, 1'b0, 1'b0);
      step();
      for (int k = 0; k < 49; k++) begin
         w = P2 | 24'(k / 24);
         drive(1'b0, 1'b0, 1'b1, w[23 - (k % 24)]);
         step();
      end
      drive(1'b0, 1'b0, 1'b1, 1'b1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      read_mem = 1'b1; node_index = 3'd0;
      #1;
      total++;
      if ({mem_ready, cfg_done, cfg_err} !== 3'b000 || node_data !== 24'h0) begin
         bad++; $display("FAIL rst_mid: flags=%b data=%h want 000 000000",
                         {mem_ready, cfg_done, cfg_err}, node_data);
      end
      drive(1'b0, 1'b0, 1'b1, 1'b1);
      step();
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      total++;
      if (cfg_err !== 1'b1 || node_data !== 24'h0) begin
         bad++; $display("FAIL rst_idle_err: err=%b data=%h want 1 000000", cfg_err, node_data);
      end
      load(1'b0, P3, 5, 1'b0, 1'b1, early);
      node_index = 3'd4;
      #1;
      total++;
      if (early || mem_ready !== 1'b1 || node_data !== (P3 | 24'd4)) begin
         bad++; $display("FAIL rst_reload: ready=%b data=%h want 1 %h",
                         mem_ready, node_data, P3 | 24'd4);
      end
   endtask

   initial begin
      reset = 1'b1;
      cfg_start = 1'b0; cfg_en = 1'b0; cfg_bit = 1'b0; read_mem = 1'b0;
      ch_index = '0; node_index = '0;
      b_cfg_start = 1'b0; b_cfg_en = 1'b0; b_cfg_bit = 1'b0; b_read_mem = 1'b0;
      b_ch_index = '0; b_node_index = '0;
      test_reset();
      test_load_continuous();
      test_load_gapped();
      test_restart_midload();
      test_cfg_err();
      test_two_channel();
      test_reset_midload();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
